// File: rtl/cw_pkg.sv
// Shared definitions for the control-word pipeline: opcode/FUNC constants,
// ALU op encodings, the packed control word and its per-stage slices.
package cw_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_NOP   = 6'h15;

  localparam logic [10:0] FN_ADD = 11'h020;
  localparam logic [10:0] FN_SUB = 11'h022;
  localparam logic [10:0] FN_AND = 11'h024;
  localparam logic [10:0] FN_OR  = 11'h025;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic rf1;
    logic rf2;
    logic en1;
  } dec_slice_t;

  typedef struct packed {
    logic       s1;
    logic       s2;
    logic [1:0] alu;
    logic       en2;
  } ex_slice_t;

  typedef struct packed {
    logic rm;
    logic wm;
    logic en3;
  } mem_slice_t;

  typedef struct packed {
    logic s3;
    logic wf1;
  } wb_slice_t;

  // Full control word, MSB first: decode | execute | memory | write-back.
  typedef struct packed {
    dec_slice_t dec;
    ex_slice_t  ex;
    mem_slice_t mem;
    wb_slice_t  wb;
  } cw_t;

  // What each later stage register still needs to carry forward.
  typedef struct packed {
    ex_slice_t  ex;
    mem_slice_t mem;
    wb_slice_t  wb;
  } ex_stage_t;

  typedef struct packed {
    mem_slice_t mem;
    wb_slice_t  wb;
  } mem_stage_t;

  localparam cw_t CW_BUBBLE = '0;

endpackage

// File: rtl/cw_decode.sv
// Combinational instruction decoder: OPCODE/FUNC to a full control word
// plus a flag marking encodings that have no defined meaning.
module cw_decode
  import cw_pkg::*;
#(
  parameter int FUNC_SIZE    = 11,
  parameter int OP_CODE_SIZE = 6,
  parameter int CW_SIZE      = 13
) (
  input  logic [OP_CODE_SIZE-1:0] opcode_i,
  input  logic [FUNC_SIZE-1:0]    func_i,
  output logic [CW_SIZE-1:0]      cw_o,
  output logic                    illegal_o
);

  cw_t cw;

  // Table lookup; anything unrecognised falls through to a bubble and is flagged.
  always_comb begin
    cw        = CW_BUBBLE;
    illegal_o = 1'b0;
    if (opcode_i == OP_CODE_SIZE'(OP_RTYPE)) begin
      cw.dec = '{rf1: 1'b1, rf2: 1'b1, en1: 1'b1};
      cw.ex  = '{s1: 1'b1, s2: 1'b0, alu: ALU_ADD, en2: 1'b1};
      cw.mem = '{rm: 1'b0, wm: 1'b0, en3: 1'b1};
      cw.wb  = '{s3: 1'b0, wf1: 1'b1};
      if (func_i == FUNC_SIZE'(FN_ADD)) begin
        cw.ex.alu = ALU_ADD;
      end else if (func_i == FUNC_SIZE'(FN_SUB)) begin
        cw.ex.alu = ALU_SUB;
      end else if (func_i == FUNC_SIZE'(FN_AND)) begin
        cw.ex.alu = ALU_AND;
      end else if (func_i == FUNC_SIZE'(FN_OR)) begin
        cw.ex.alu = ALU_OR;
      end else begin
        cw        = CW_BUBBLE;
        illegal_o = 1'b1;
      end
    end else if (opcode_i == OP_CODE_SIZE'(OP_ADDI)) begin
      cw.dec = '{rf1: 1'b1, rf2: 1'b0, en1: 1'b1};
      cw.ex  = '{s1: 1'b1, s2: 1'b1, alu: ALU_ADD, en2: 1'b1};
      cw.mem = '{rm: 1'b0, wm: 1'b0, en3: 1'b1};
      cw.wb  = '{s3: 1'b0, wf1: 1'b1};
    end else if (opcode_i == OP_CODE_SIZE'(OP_LW)) begin
      cw.dec = '{rf1: 1'b1, rf2: 1'b0, en1: 1'b1};
      cw.ex  = '{s1: 1'b1, s2: 1'b1, alu: ALU_ADD, en2: 1'b1};
      cw.mem = '{rm: 1'b1, wm: 1'b0, en3: 1'b1};
      cw.wb  = '{s3: 1'b1, wf1: 1'b1};
    end else if (opcode_i == OP_CODE_SIZE'(OP_SW)) begin
      cw.dec = '{rf1: 1'b1, rf2: 1'b1, en1: 1'b1};
      cw.ex  = '{s1: 1'b1, s2: 1'b1, alu: ALU_ADD, en2: 1'b1};
      cw.mem = '{rm: 1'b0, wm: 1'b1, en3: 1'b1};
      cw.wb  = '{s3: 1'b0, wf1: 1'b0};
    end else if (opcode_i == OP_CODE_SIZE'(OP_NOP)) begin
      cw = CW_BUBBLE;
    end else begin
      illegal_o = 1'b1;
    end
  end

  assign cw_o = CW_SIZE'(cw);

endmodule

// File: rtl/cw_pipe_ctrl.sv
// Four-stage control-word pipeline with load-use stall and branch flush.
// Optional feature: define CW_PIPE_ILLEGAL_TRAP_EN to get a one-cycle
// ILLEGAL pulse alongside the decode slice of an undecodable instruction.
module cw_pipe_ctrl
  import cw_pkg::*;
#(
  parameter int FUNC_SIZE    = 11,
  parameter int OP_CODE_SIZE = 6,
  parameter int CW_SIZE      = 13
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [OP_CODE_SIZE-1:0] OPCODE,
  input  logic [FUNC_SIZE-1:0]    FUNC,
  input  logic                    IR_VALID,
  output logic                    IR_READY,
  input  logic                    STALL,
  input  logic                    FLUSH,
  output logic                    RF1,
  output logic                    RF2,
  output logic                    EN1,
  output logic                    S1,
  output logic                    S2,
  output logic                    ALU1,
  output logic                    ALU2,
  output logic                    EN2,
  output logic                    RM,
  output logic                    WM,
  output logic                    EN3,
  output logic                    S3,
  output logic                    WF1,
  output logic                    ILLEGAL
);

  logic [CW_SIZE-1:0] decWord;
  logic               decIllegal;
  cw_t                decCw;

  cw_t        decStage_q, decStage_d;
  ex_stage_t  exStage_q,  exStage_d;
  mem_stage_t memStage_q, memStage_d;
  wb_slice_t  wbStage_q,  wbStage_d;

  cw_decode #(
    .FUNC_SIZE    (FUNC_SIZE),
    .OP_CODE_SIZE (OP_CODE_SIZE),
    .CW_SIZE      (CW_SIZE)
  ) u_decode (
    .opcode_i  (OPCODE),
    .func_i    (FUNC),
    .cw_o      (decWord),
    .illegal_o (decIllegal)
  );

  assign decCw    = decWord;
  assign IR_READY = ~STALL;

  // Next-state: memory and write-back always advance; flush beats stall.
  always_comb begin
    memStage_d = '{mem: exStage_q.mem, wb: exStage_q.wb};
    wbStage_d  = memStage_q.wb;
    decStage_d = decStage_q;
    exStage_d  = '0;
    if (FLUSH) begin
      decStage_d = CW_BUBBLE;
      exStage_d  = '0;
    end else if (STALL) begin
      decStage_d = decStage_q;
      exStage_d  = '0;
    end else begin
      decStage_d = IR_VALID ? decCw : CW_BUBBLE;
      exStage_d  = '{ex: decStage_q.ex, mem: decStage_q.mem, wb: decStage_q.wb};
    end
  end

  // Stage registers; reset wipes every in-flight control word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      decStage_q <= CW_BUBBLE;
      exStage_q  <= '0;
      memStage_q <= '0;
      wbStage_q  <= '0;
    end else begin
      decStage_q <= decStage_d;
      exStage_q  <= exStage_d;
      memStage_q <= memStage_d;
      wbStage_q  <= wbStage_d;
    end
  end

`ifdef CW_PIPE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Flag only instructions actually accepted into decode this cycle.
  always_comb begin
    illegal_d = IR_VALID & ~STALL & ~FLUSH & decIllegal;
  end

  // Single-cycle trap pulse lined up with the decode slice.
  always_ff @(posedge CLK) begin
    if (RST) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign ILLEGAL = illegal_q;
`else
  logic unusedIllegal;
  assign unusedIllegal = decIllegal;
  assign ILLEGAL       = 1'b0;
`endif

  assign RF1  = decStage_q.dec.rf1;
  assign RF2  = decStage_q.dec.rf2;
  assign EN1  = decStage_q.dec.en1;
  assign S1   = exStage_q.ex.s1;
  assign S2   = exStage_q.ex.s2;
  assign ALU1 = exStage_q.ex.alu[1];
  assign ALU2 = exStage_q.ex.alu[0];
  assign EN2  = exStage_q.ex.en2;
  assign RM   = memStage_q.mem.rm;
  assign WM   = memStage_q.mem.wm;
  assign EN3  = memStage_q.mem.en3;
  assign S3   = wbStage_q.s3;
  assign WF1  = wbStage_q.wf1;

endmodule

// File: tb/tb_cw_pipe_ctrl.sv
// Scoreboard bench for cw_pipe_ctrl: each stimulus cycle queues the
// hand-computed outputs expected during that cycle; a negedge monitor checks them.
module tb_cw_pipe_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [5:0]  OPCODE;
  logic [10:0] FUNC;
  logic        IR_VALID, IR_READY, STALL, FLUSH;
  logic        RF1, RF2, EN1, S1, S2, ALU1, ALU2, EN2, RM, WM, EN3, S3, WF1, ILLEGAL;

`ifdef CW_PIPE_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  // Hand-written control words: RF1 RF2 EN1 | S1 S2 ALU EN2 | RM WM EN3 | S3 WF1
  localparam logic [12:0] Z      = 13'b000_00000_000_00;
  localparam logic [12:0] W_ADD  = 13'b111_10001_001_01;
  localparam logic [12:0] W_SUB  = 13'b111_10011_001_01;
  localparam logic [12:0] W_AND  = 13'b111_10101_001_01;
  localparam logic [12:0] W_OR   = 13'b111_10111_001_01;
  localparam logic [12:0] W_ADDI = 13'b101_11001_001_01;
  localparam logic [12:0] W_LW   = 13'b101_11001_101_11;
  localparam logic [12:0] W_SW   = 13'b111_11001_011_00;

  typedef struct {
    logic [14:0] v;
    string       tag;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  logic [14:0] actual;
  assign actual = {IR_READY, RF1, RF2, EN1, S1, S2, ALU1, ALU2, EN2,
                   RM, WM, EN3, S3, WF1, ILLEGAL};

  cw_pipe_ctrl dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNC(FUNC),
    .IR_VALID(IR_VALID), .IR_READY(IR_READY), .STALL(STALL), .FLUSH(FLUSH),
    .RF1(RF1), .RF2(RF2), .EN1(EN1),
    .S1(S1), .S2(S2), .ALU1(ALU1), .ALU2(ALU2), .EN2(EN2),
    .RM(RM), .WM(WM), .EN3(EN3),
    .S3(S3), .WF1(WF1), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // Compose the visible outputs from whichever word sits in each stage.
  function automatic logic [14:0] mk(input logic [12:0] d, input logic [12:0] e,
                                     input logic [12:0] m, input logic [12:0] w,
                                     input logic ill, input logic rdy);
    return {rdy, d[12:10], e[9:5], m[4:2], w[1:0], ill};
  endfunction

  // Drive one cycle of inputs and queue what the outputs must read in that cycle.
  task automatic applyStimulus(input string tag, input logic v, input logic [5:0] op,
                               input logic [10:0] fn, input logic st, input logic fl,
                               input logic rs, input logic [14:0] ev);
    exp_t x;
    IR_VALID = v;
    OPCODE   = op;
    FUNC     = fn;
    STALL    = st;
    FLUSH    = fl;
    RST      = rs;
    x.v      = ev;
    x.tag    = tag;
    expQ.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  // Pop one expectation per cycle and compare against the live outputs.
  task automatic checkOutput();
    exp_t x;
    if (expQ.size() != 0) begin
      x = expQ.pop_front();
      checks++;
      if (actual !== x.v) begin
        errors++;
        $display("[TB] FAIL %s got %b want %b (rdy,dec3,ex5,mem3,wb2,ill)",
                 x.tag, actual, x.v);
      end
    end
  endtask

  always @(negedge CLK) checkOutput();

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    RST = 1'b1; OPCODE = '0; FUNC = '0; IR_VALID = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    @(posedge CLK);
    #1;
    applyStimulus("reset", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));

    // LW walks through all four stages
    applyStimulus("lw c0", 1, 6'h23, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("lw c1", 0, 6'h00, 11'h000, 0, 0, 0, mk(W_LW, Z, Z, Z, 0, 1));
    applyStimulus("lw c2", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, W_LW, Z, Z, 0, 1));
    applyStimulus("lw c3", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, W_LW, Z, 0, 1));
    applyStimulus("lw c4", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, W_LW, 0, 1));
    applyStimulus("lw c5", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));

    // Back-to-back R-types
    applyStimulus("rr c0", 1, 6'h00, 11'h020, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("rr c1", 1, 6'h00, 11'h022, 0, 0, 0, mk(W_ADD, Z, Z, Z, 0, 1));
    applyStimulus("rr c2", 1, 6'h00, 11'h024, 0, 0, 0, mk(W_SUB, W_ADD, Z, Z, 0, 1));
    applyStimulus("rr c3", 1, 6'h00, 11'h025, 0, 0, 0, mk(W_AND, W_SUB, W_ADD, Z, 0, 1));
    applyStimulus("rr c4", 0, 6'h00, 11'h000, 0, 0, 0, mk(W_OR, W_AND, W_SUB, W_ADD, 0, 1));
    applyStimulus("rr c5", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, W_OR, W_AND, W_SUB, 0, 1));
    applyStimulus("rr c6", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, W_OR, W_AND, 0, 1));
    applyStimulus("rr c7", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, W_OR, 0, 1));
    applyStimulus("rr c8", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));

    // Load-use stall
    applyStimulus("st c0", 1, 6'h23, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("st c1", 1, 6'h00, 11'h020, 1, 0, 0, mk(W_LW, Z, Z, Z, 0, 0));
    applyStimulus("st c2", 1, 6'h00, 11'h020, 0, 0, 0, mk(W_LW, Z, Z, Z, 0, 1));
    applyStimulus("st c3", 0, 6'h00, 11'h000, 0, 0, 0, mk(W_ADD, W_LW, Z, Z, 0, 1));
    applyStimulus("st c4", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, W_ADD, W_LW, Z, 0, 1));
    applyStimulus("st c5", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, W_ADD, W_LW, 0, 1));
    applyStimulus("st c6", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, W_ADD, 0, 1));
    applyStimulus("st c7", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));

    // Stall plus flush with SW in decode, then a plain flush discarding an offer
    applyStimulus("fl c0", 1, 6'h08, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("fl c1", 1, 6'h2B, 11'h000, 0, 0, 0, mk(W_ADDI, Z, Z, Z, 0, 1));
    applyStimulus("fl c2", 1, 6'h23, 11'h000, 1, 1, 0, mk(W_SW, W_ADDI, Z, Z, 0, 0));
    applyStimulus("fl c3", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, W_ADDI, Z, 0, 1));
    applyStimulus("fl c4", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, W_ADDI, 0, 1));
    applyStimulus("fl c5", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("fl c6", 1, 6'h00, 11'h020, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("fl c7", 1, 6'h00, 11'h022, 0, 1, 0, mk(W_ADD, Z, Z, Z, 0, 1));
    applyStimulus("fl c8", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("fl c9", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));

    // SW end to end
    applyStimulus("sw c0", 1, 6'h2B, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("sw c1", 0, 6'h00, 11'h000, 0, 0, 0, mk(W_SW, Z, Z, Z, 0, 1));
    applyStimulus("sw c2", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, W_SW, Z, Z, 0, 1));
    applyStimulus("sw c3", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, W_SW, Z, 0, 1));
    applyStimulus("sw c4", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, W_SW, 0, 1));
    applyStimulus("sw c5", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));

    // Reset mid-stream with ADDI in execute
    applyStimulus("rs c0", 1, 6'h08, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("rs c1", 1, 6'h00, 11'h020, 0, 0, 0, mk(W_ADDI, Z, Z, Z, 0, 1));
    applyStimulus("rs c2", 1, 6'h00, 11'h022, 0, 0, 1, mk(W_ADD, W_ADDI, Z, Z, 0, 1));
    applyStimulus("rs c3", 1, 6'h00, 11'h020, 1, 0, 1, mk(Z, Z, Z, Z, 0, 0));
    applyStimulus("rs c4", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("rs c5", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));

    // Undecodable encodings, NOP, and an illegal offer refused by stall
    applyStimulus("il c0", 1, 6'h3F, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("il c1", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, TRAP, 1));
    applyStimulus("il c2", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("il c3", 1, 6'h00, 11'h021, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("il c4", 1, 6'h15, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, TRAP, 1));
    applyStimulus("il c5", 1, 6'h3F, 11'h000, 1, 0, 0, mk(Z, Z, Z, Z, 0, 0));
    applyStimulus("il c6", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));
    applyStimulus("il c7", 0, 6'h00, 11'h000, 0, 0, 0, mk(Z, Z, Z, Z, 0, 1));

    @(negedge CLK);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
